// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: button debounce and press-driven ALU control FSM.
// Optional back button enabled by defining ALU_CTRL_BACK_EN.

// Synchroniser, debouncer and rising-edge press detector.
module alu_ctrl_deb #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_db_q;
    logic [CW-1:0] r_cnt;

    // Two-FF synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after it has been stable long enough;
    // any bounce back to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
        end else begin
            r_db_q <= r_db;
            if (r_s2 != r_db) begin
                if (r_cnt == CMAX) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_db & ~r_db_q;
endmodule

module alu_ctrl_fsm #(
    parameter int DEB_CYCLES = 16,
    parameter int FN_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_center,
`ifdef ALU_CTRL_BACK_EN
    input  logic            btn_back,
`endif
    output logic [1:0]      reg_ctrl,
    output logic [FN_W-1:0] fn,
    output logic            valid
);
    localparam logic [FN_W-1:0] FN_ADD  = FN_W'(0);
    localparam logic [FN_W-1:0] FN_SUB  = FN_W'(1);
    localparam logic [FN_W-1:0] FN_MOD3 = FN_W'(2);
    localparam logic [FN_W-1:0] FN_NONE = {FN_W{1'b1}};

    typedef enum logic [2:0] {
        S_WAIT_A = 3'd0,
        S_WAIT_B = 3'd1,
        S_ADD    = 3'd2,
        S_SUB    = 3'd3,
        S_MOD3   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_nxt;
    logic [1:0]      w_ld;
    logic [1:0]      r_reg_ctrl;
    logic [FN_W-1:0] r_fn;
    logic            r_valid;
    logic            w_fwd;

    alu_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fwd (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_center),
        .o_press (w_fwd)
    );

`ifdef ALU_CTRL_BACK_EN
    logic w_bk;

    alu_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_bk (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_back),
        .o_press (w_bk)
    );
`endif

    function automatic logic [FN_W-1:0] f_fn(input state_t s);
        case (s)
            S_ADD:   return FN_ADD;
            S_SUB:   return FN_SUB;
            S_MOD3:  return FN_MOD3;
            default: return FN_NONE;
        endcase
    endfunction

    function automatic logic f_valid(input state_t s);
        return (s == S_ADD) || (s == S_SUB) || (s == S_MOD3);
    endfunction

    // Next state and load pulse; forward press takes priority over back.
    always_comb begin
        w_nxt = r_state;
        w_ld  = 2'b00;
        case (r_state)
            S_WAIT_A: begin
                if (w_fwd) begin
                    w_nxt = S_WAIT_B;
                    w_ld  = 2'b01;
                end
`ifdef ALU_CTRL_BACK_EN
                else if (w_bk) w_nxt = S_MOD3;
`endif
            end
            S_WAIT_B: begin
                if (w_fwd) begin
                    w_nxt = S_ADD;
                    w_ld  = 2'b10;
                end
`ifdef ALU_CTRL_BACK_EN
                else if (w_bk) w_nxt = S_WAIT_A;
`endif
            end
            S_ADD: begin
                if (w_fwd) w_nxt = S_SUB;
`ifdef ALU_CTRL_BACK_EN
                else if (w_bk) w_nxt = S_WAIT_B;
`endif
            end
            S_SUB: begin
                if (w_fwd) w_nxt = S_MOD3;
`ifdef ALU_CTRL_BACK_EN
                else if (w_bk) w_nxt = S_ADD;
`endif
            end
            S_MOD3: begin
                if (w_fwd) w_nxt = S_WAIT_A;
`ifdef ALU_CTRL_BACK_EN
                else if (w_bk) w_nxt = S_SUB;
`endif
            end
            default: w_nxt = S_WAIT_A;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_WAIT_A;
            r_reg_ctrl <= 2'b00;
            r_fn       <= FN_NONE;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_reg_ctrl <= w_ld;
            r_fn       <= f_fn(w_nxt);
            r_valid    <= f_valid(w_nxt);
        end
    end

    assign reg_ctrl = r_reg_ctrl;
    assign fn       = r_fn;
    assign valid    = r_valid;
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed checks of debounce latency, press
// sequencing, bounce rejection, long hold and reset behaviour.
module tb_alu_ctrl_fsm;
    localparam int DEB = 4;
    localparam logic [3:0] F = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_center = 1'b0;
`ifdef ALU_CTRL_BACK_EN
    logic       btn_back = 1'b0;
`endif
    logic [1:0] reg_ctrl;
    logic [3:0] fn;
    logic       valid;

    int n_chk = 0;
    int n_err = 0;

    alu_ctrl_fsm #(.DEB_CYCLES(DEB), .FN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_center (btn_center),
`ifdef ALU_CTRL_BACK_EN
        .btn_back   (btn_back),
`endif
        .reg_ctrl   (reg_ctrl),
        .fn         (fn),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".rc"}, 32'(reg_ctrl), 32'(2'b00));
        check({tag, ".fn"}, 32'(fn), 32'(F));
        check({tag, ".valid"}, 32'(valid), 32'(1'b0));
    endtask

    // Hold a button for hi cycles then low for lo cycles. The event
    // lands after edge DEB+3 = 7 of the window.
    task automatic press(input string tag, input int hi, input int lo,
                         input logic f, input logic b,
                         input logic [1:0] rc,
                         input logic [3:0] fo, input logic [3:0] fnw,
                         input logic vo, input logic vn);
        for (int k = 1; k <= hi + lo; k++) begin
            btn_center = f && (k <= hi);
`ifdef ALU_CTRL_BACK_EN
            btn_back = b && (k <= hi);
`endif
            tick();
            check({tag, ".rc"}, 32'(reg_ctrl),
                  32'((k == DEB + 3) ? rc : 2'b00));
            check({tag, ".fn"}, 32'(fn),
                  32'((k >= DEB + 3) ? fnw : fo));
            check({tag, ".valid"}, 32'(valid),
                  32'((k >= DEB + 3) ? vn : vo));
        end
        btn_center = 1'b0;
`ifdef ALU_CTRL_BACK_EN
        btn_back = 1'b0;
`endif
    endtask

    initial begin
        // 1: reset
        rst = 1'b1;
        tick();
        chk_idle("rst1");
        tick();
        chk_idle("rst2");
        rst = 1'b0;
        tick();
        chk_idle("rst_rel");

        // 2: first press loads A
        press("load_a", 12, 12, 1'b1, 1'b0, 2'b01, F, F, 1'b0, 1'b0);

        // 3: bounce pattern 1,1,1,0 never debounces
        for (int k = 0; k < 40; k++) begin
            btn_center = (k % 4) != 3;
            tick();
            chk_idle("bounce");
        end
        press("quiet", 0, 12, 1'b0, 1'b0, 2'b00, F, F, 1'b0, 1'b0);

        // reset from WAIT_B
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("rst_b");

        // 4: five clean presses
        press("p1", 10, 10, 1'b1, 1'b0, 2'b01, F, F, 1'b0, 1'b0);
        press("p2", 10, 10, 1'b1, 1'b0, 2'b10, F, 4'h0, 1'b0, 1'b1);
        press("p3", 10, 10, 1'b1, 1'b0, 2'b00, 4'h0, 4'h1, 1'b1, 1'b1);
        press("p4", 10, 10, 1'b1, 1'b0, 2'b00, 4'h1, 4'h2, 1'b1, 1'b1);
        press("p5", 10, 10, 1'b1, 1'b0, 2'b00, 4'h2, F, 1'b1, 1'b0);

        // 5: long hold is one press, re-press is the next
        press("hold", 100, 10, 1'b1, 1'b0, 2'b01, F, F, 1'b0, 1'b0);
        press("repress", 10, 10, 1'b1, 1'b0, 2'b10, F, 4'h0, 1'b0, 1'b1);
        press("to_sub", 10, 10, 1'b1, 1'b0, 2'b00, 4'h0, 4'h1, 1'b1, 1'b1);
        check("in_sub.fn", 32'(fn), 32'(4'h1));
        rst = 1'b1;
        tick();
        chk_idle("rst_sub");

        // button held through reset is a fresh press after release
        btn_center = 1'b1;
        tick();
        chk_idle("rst_held");
        rst = 1'b0;
        press("held_rst", 10, 10, 1'b1, 1'b0, 2'b01, F, F, 1'b0, 1'b0);

`ifdef ALU_CTRL_BACK_EN
        // 6: back from ADD, then forward beats simultaneous back
        press("b_add", 10, 10, 1'b1, 1'b0, 2'b10, F, 4'h0, 1'b0, 1'b1);
        press("back", 10, 10, 1'b0, 1'b1, 2'b00, 4'h0, F, 1'b1, 1'b0);
        press("both", 10, 10, 1'b1, 1'b1, 2'b10, F, 4'h0, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
